// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Command and status bundle between the instruction decoder
//               (master) and the 6502 program-counter sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;

    logic        pcCmdValid_IN;
    logic [2:0]  pcCmd_IN;
    logic [1:0]  vectorSel_IN;
    logic [7:0]  dataBus_IN;
    logic [15:0] pc_OUT;
    logic        pcBusy_OUT;
    logic        vecRead_EN;
    logic [15:0] vecAddr_OUT;
    logic        pageCross_OUT;

    // Decoder / bus side: issues commands and supplies the data byte
    modport master (
        output pcCmdValid_IN,
        output pcCmd_IN,
        output vectorSel_IN,
        output dataBus_IN,
        input  pc_OUT,
        input  pcBusy_OUT,
        input  vecRead_EN,
        input  vecAddr_OUT,
        input  pageCross_OUT
    );

    // Sequencer side
    modport slave (
        input  pcCmdValid_IN,
        input  pcCmd_IN,
        input  vectorSel_IN,
        input  dataBus_IN,
        output pc_OUT,
        output pcBusy_OUT,
        output vecRead_EN,
        output vecAddr_OUT,
        output pageCross_OUT
    );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Owner of the MOS 6502 program counter. Handles increment,
//               two-byte absolute load, relative branch with page-cross
//               fix-up cycle, and interrupt/reset vector fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer (
    input  wire             clk,
    input  wire             rst,
    pc_sequencer_if.slave   bus
);

    // Command codes
    localparam logic [2:0]  c_CMD_HOLD      = 3'd0;
    localparam logic [2:0]  c_CMD_INC       = 3'd1;
    localparam logic [2:0]  c_CMD_LOAD_LOW  = 3'd2;
    localparam logic [2:0]  c_CMD_LOAD_HIGH = 3'd3;
    localparam logic [2:0]  c_CMD_BRANCH    = 3'd4;
    localparam logic [2:0]  c_CMD_VECTOR    = 3'd5;

    // Vector bases
    localparam logic [15:0] c_VEC_NMI       = 16'hFFFA;
    localparam logic [15:0] c_VEC_RESET     = 16'hFFFC;
    localparam logic [15:0] c_VEC_IRQ       = 16'hFFFE;

    // FSM encoding
    localparam logic [1:0]  c_ST_IDLE       = 2'd0;
    localparam logic [1:0]  c_ST_BRANCH_FIX = 2'd1;
    localparam logic [1:0]  c_ST_VEC_LOW    = 2'd2;
    localparam logic [1:0]  c_ST_VEC_HIGH   = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [7:0]  r_temp_low;
    logic [15:0] r_vec_base;
    logic        r_fix_up;       // 1: PCH increments in BRANCH_FIX, 0: decrements
    logic        r_page_cross;

    logic [1:0]  w_state_next;
    logic [15:0] w_pc_next;
    logic [7:0]  w_temp_next;
    logic [15:0] w_vec_base_next;
    logic        w_fix_up_next;
    logic [8:0]  w_sum9;
    logic        w_cross;
    logic [15:0] w_vec_sel_base;
    logic [15:0] w_vec_addr;

    // Low-byte branch sum; the offset's sign bit decides how to read the carry
    assign w_sum9  = {1'b0, r_pc[7:0]} + {1'b0, bus.dataBus_IN};
    assign w_cross = bus.dataBus_IN[7] ? ~w_sum9[8] : w_sum9[8];

    // Vector base selected by the decoder; code 3 aliases IRQ/BRK
    always_comb begin
        w_vec_sel_base = c_VEC_IRQ;
        case (bus.vectorSel_IN)
            2'd0:    w_vec_sel_base = c_VEC_NMI;
            2'd1:    w_vec_sel_base = c_VEC_RESET;
            default: w_vec_sel_base = c_VEC_IRQ;
        endcase
    end

    // Next-state and datapath update for each FSM state
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_temp_next     = r_temp_low;
        w_vec_base_next = r_vec_base;
        w_fix_up_next   = r_fix_up;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.pcCmdValid_IN) begin
                    case (bus.pcCmd_IN)
                        c_CMD_INC: begin
                            w_pc_next = r_pc + 16'd1;
                        end
                        c_CMD_LOAD_LOW: begin
                            w_temp_next = bus.dataBus_IN;
                        end
                        c_CMD_LOAD_HIGH: begin
                            w_pc_next = {bus.dataBus_IN, r_temp_low};
                        end
                        c_CMD_BRANCH: begin
                            w_pc_next = {r_pc[15:8], w_sum9[7:0]};
                            if (w_cross) begin
                                w_state_next  = c_ST_BRANCH_FIX;
                                w_fix_up_next = ~bus.dataBus_IN[7];
                            end
                        end
                        c_CMD_VECTOR: begin
                            w_vec_base_next = w_vec_sel_base;
                            w_state_next    = c_ST_VEC_LOW;
                        end
                        default: begin
                            // HOLD and reserved codes leave everything unchanged
                        end
                    endcase
                end
            end
            c_ST_BRANCH_FIX: begin
                w_pc_next[15:8] = r_fix_up ? (r_pc[15:8] + 8'd1) : (r_pc[15:8] - 8'd1);
                w_state_next    = c_ST_IDLE;
            end
            c_ST_VEC_LOW: begin
                // Memory answers in the same cycle the vector address is driven
                w_temp_next  = bus.dataBus_IN;
                w_state_next = c_ST_VEC_HIGH;
            end
            c_ST_VEC_HIGH: begin
                w_pc_next    = {bus.dataBus_IN, r_temp_low};
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // State registers; reset lands in VEC_LOW so a RESET vector fetch follows release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_VEC_LOW;
            r_pc         <= 16'h0000;
            r_temp_low   <= 8'h00;
            r_vec_base   <= c_VEC_RESET;
            r_fix_up     <= 1'b0;
            r_page_cross <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_temp_low   <= w_temp_next;
            r_vec_base   <= w_vec_base_next;
            r_fix_up     <= w_fix_up_next;
            r_page_cross <= (r_state == c_ST_BRANCH_FIX);
        end
    end

    // Vector address is driven only during the two fetch cycles
    always_comb begin
        w_vec_addr = 16'h0000;
        if (r_state == c_ST_VEC_LOW) begin
            w_vec_addr = r_vec_base;
        end else if (r_state == c_ST_VEC_HIGH) begin
            w_vec_addr = r_vec_base + 16'd1;
        end
    end

    assign bus.pc_OUT        = r_pc;
    assign bus.pcBusy_OUT    = (r_state != c_ST_IDLE);
    assign bus.vecRead_EN    = (r_state == c_ST_VEC_LOW) || (r_state == c_ST_VEC_HIGH);
    assign bus.vecAddr_OUT   = w_vec_addr;
    assign bus.pageCross_OUT = r_page_cross;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. Each step
//               drives one cycle of stimulus, queues the expected outputs
//               after the next rising edge, and compares them at edge + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [2:0] c_HOLD = 3'd0;
    localparam logic [2:0] c_INC  = 3'd1;
    localparam logic [2:0] c_LL   = 3'd2;
    localparam logic [2:0] c_LH   = 3'd3;
    localparam logic [2:0] c_BR   = 3'd4;
    localparam logic [2:0] c_VEC  = 3'd5;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic        busy;
        logic        pcross;
        logic [15:0] vaddr;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   r_sb[$];
    int     errors;
    int     checks;

    pc_sequencer_if u_if ();

    pc_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare every output against it
    task automatic compare_out();
        exp_t e;
        if (r_sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = r_sb.pop_front();
            chk({e.tag, ".pc"},     u_if.pc_OUT,                 e.pc);
            chk({e.tag, ".busy"},   {15'd0, u_if.pcBusy_OUT},    {15'd0, e.busy});
            chk({e.tag, ".pcross"}, {15'd0, u_if.pageCross_OUT}, {15'd0, e.pcross});
            chk({e.tag, ".vaddr"},  u_if.vecAddr_OUT,            e.vaddr);
            chk({e.tag, ".vread"},  {15'd0, u_if.vecRead_EN},    {15'd0, (e.vaddr != 16'h0000)});
        end
    endtask

    // One cycle: drive inputs, queue expectation, clock, compare
    task automatic step(input logic r, input logic v, input logic [2:0] cmd,
                        input logic [1:0] sel, input logic [7:0] data, input string tag,
                        input logic [15:0] e_pc, input logic e_busy, input logic e_pcross,
                        input logic [15:0] e_vaddr);
        exp_t e;
        @(negedge clk);
        rst                = r;
        u_if.pcCmdValid_IN = v;
        u_if.pcCmd_IN      = cmd;
        u_if.vectorSel_IN  = sel;
        u_if.dataBus_IN    = data;
        e.tag    = tag;
        e.pc     = e_pc;
        e.busy   = e_busy;
        e.pcross = e_pcross;
        e.vaddr  = e_vaddr;
        r_sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Two-step absolute load to place the PC at a known value
    task automatic load_pc(input logic [15:0] val, input logic [15:0] cur, input string tag);
        step(0, 1, c_LL, 0, val[7:0],  {tag, "_ll"}, cur, 0, 0, 16'h0000);
        step(0, 1, c_LH, 0, val[15:8], {tag, "_lh"}, val, 0, 0, 16'h0000);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst                = 1'b1;
        u_if.pcCmdValid_IN = 1'b0;
        u_if.pcCmd_IN      = c_HOLD;
        u_if.vectorSel_IN  = 2'd0;
        u_if.dataBus_IN    = 8'h00;

        // Reset vector fetch
        step(1, 1, c_INC, 0, 8'h00, "rst0", 16'h0000, 1, 0, 16'hFFFC);
        step(1, 0, c_HOLD, 0, 8'h00, "rst1", 16'h0000, 1, 0, 16'hFFFC);
        step(0, 0, c_HOLD, 0, 8'h34, "rvec_lo", 16'h0000, 1, 0, 16'hFFFD);
        step(0, 0, c_HOLD, 0, 8'h12, "rvec_hi", 16'h1234, 0, 0, 16'h0000);

        // Absolute load / INC wraps
        load_pc(16'h00FF, 16'h1234, "ld00ff");
        step(0, 1, c_INC, 0, 8'h00, "inc_00ff", 16'h0100, 0, 0, 16'h0000);
        load_pc(16'hFFFF, 16'h0100, "ldffff");
        step(0, 1, c_INC, 0, 8'h00, "inc_ffff", 16'h0000, 0, 0, 16'h0000);
        step(0, 1, c_LL, 0, 8'hCD, "abs_ll", 16'h0000, 0, 0, 16'h0000);
        step(0, 1, c_LH, 0, 8'hAB, "abs_lh", 16'hABCD, 0, 0, 16'h0000);
        step(0, 1, 3'd6, 0, 8'h55, "reserved6", 16'hABCD, 0, 0, 16'h0000);

        // Forward branch across a page; INC during fix-up is ignored
        load_pc(16'h10F0, 16'hABCD, "ld10f0");
        step(0, 1, c_BR,  0, 8'h20, "brf_e1", 16'h1010, 1, 0, 16'h0000);
        step(0, 1, c_INC, 0, 8'h00, "brf_e2", 16'h1110, 0, 1, 16'h0000);
        step(0, 1, c_HOLD, 0, 8'h00, "brf_e3", 16'h1110, 0, 0, 16'h0000);

        // Backward branch across a page
        load_pc(16'h1005, 16'h1110, "ld1005a");
        step(0, 1, c_BR,   0, 8'hF0, "brb_e1", 16'h10F5, 1, 0, 16'h0000);
        step(0, 0, c_HOLD, 0, 8'h00, "brb_e2", 16'h0FF5, 0, 1, 16'h0000);
        step(0, 0, c_HOLD, 0, 8'h00, "brb_e3", 16'h0FF5, 0, 0, 16'h0000);

        // Branch within the page
        load_pc(16'h1005, 16'h0FF5, "ld1005b");
        step(0, 1, c_BR, 0, 8'h10, "brn", 16'h1015, 0, 0, 16'h0000);
        step(0, 1, c_BR, 0, 8'hFB, "brn_back", 16'h1010, 0, 0, 16'h0000);

        // NMI vector; INC during VEC_LOW is ignored
        step(0, 1, c_VEC, 2'd0, 8'h00, "nmi_acc", 16'h1010, 1, 0, 16'hFFFA);
        step(0, 1, c_INC, 2'd1, 8'h78, "nmi_lo",  16'h1010, 1, 0, 16'hFFFB);
        step(0, 0, c_HOLD, 0,   8'h56, "nmi_hi",  16'h5678, 0, 0, 16'h0000);
        step(0, 1, c_INC, 0,    8'h00, "post_nmi_inc", 16'h5679, 0, 0, 16'h0000);

        // Reset during BRANCH_FIX: no PCH fix-up, fetch restarts
        load_pc(16'h10F0, 16'h5679, "ld10f0b");
        step(0, 1, c_BR,  0, 8'h20, "rbf_e1",  16'h1010, 1, 0, 16'h0000);
        step(1, 0, c_HOLD, 0, 8'h00, "rbf_rst", 16'h0000, 1, 0, 16'hFFFC);
        step(0, 0, c_HOLD, 0, 8'hAA, "rbf_lo",  16'h0000, 1, 0, 16'hFFFD);
        step(0, 0, c_HOLD, 0, 8'hBB, "rbf_hi",  16'hBBAA, 0, 0, 16'h0000);

        // IRQ vector (select 3 aliases IRQ), reset during VEC_HIGH
        step(0, 1, c_VEC, 2'd3, 8'h00, "irq_acc", 16'hBBAA, 1, 0, 16'hFFFE);
        step(0, 0, c_HOLD, 0,   8'h11, "irq_lo",  16'hBBAA, 1, 0, 16'hFFFF);
        step(1, 0, c_HOLD, 0,   8'h22, "rvh_rst", 16'h0000, 1, 0, 16'hFFFC);
        step(0, 0, c_HOLD, 0,   8'h33, "rvh_lo",  16'h0000, 1, 0, 16'hFFFD);
        step(0, 0, c_HOLD, 0,   8'h44, "rvh_hi",  16'h4433, 0, 0, 16'h0000);

        // BRK vector via select 2
        step(0, 1, c_VEC, 2'd2, 8'h00, "brk_acc", 16'h4433, 1, 0, 16'hFFFE);
        step(0, 0, c_HOLD, 0,   8'h0D, "brk_lo",  16'h4433, 1, 0, 16'hFFFF);
        step(0, 0, c_HOLD, 0,   8'hC0, "brk_hi",  16'hC00D, 0, 0, 16'h0000);

        if (r_sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", r_sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
